uid_response_park: RTL and testbench
====================================

UID_RESPONSE_PARK -- requirements
Module: uid_response_park

Interface
REQ-001 SHALL have parameter NUM_UIDS, default 16, number of internal UIDs.
REQ-002 SHALL have parameter MAX_BEATS, default 8, per-UID FIFO depth, power of 2, >=2.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, RDATA width.
REQ-004 SHALL have parameter RESP_WIDTH, default 2, RRESP width.
REQ-005 SHALL have parameter ID_WIDTH, default $clog2(NUM_UIDS), UID width.
REQ-006 SHALL have parameter DQ_DEPTH, default 4, drain-request queue depth, power of 2.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port r_in  r_if.receiver  -  incoming beats; id = UID.
REQ-010 SHALL have port r_out  r_if.sender  -  outgoing beats; id = active UID.
REQ-011 SHALL have port drain_req_valid / drain_req_ready / drain_req_uid  input / output / input  1 / 1 / ID_WIDTH  drain request handshake.
REQ-012 SHALL have port flush_valid / flush_ready / flush_uid  input / output / input  1 / 1 / ID_WIDTH  discard-UID handshake.
REQ-013 SHALL have port uid_freed_valid / uid_freed_uid / uid_freed_err  output  1 / ID_WIDTH / 1  UID-release pulse, UID, sticky error flag.
REQ-014 SHALL have port proto_err  output  1  pulse when a beat is dropped (REQ-022).
REQ-015 SHALL have port occupancy  output  $clog2(NUM_UIDS*MAX_BEATS+1)  total parked beats.
REQ-016 SHALL have port full  output  1  occupancy == NUM_UIDS*MAX_BEATS.

Function
REQ-017 SHALL keep one circular FIFO per UID: data, resp, wptr, rptr, count, seen_last, err_sticky; pointers wrap MAX_BEATS-1 -> 0.
REQ-018 SHALL drive r_in.ready = !fifo_full[r_in.id]; a write occurs on r_in.valid & r_in.ready.
REQ-019 SHALL set seen_last[uid] on an accepted beat with last=1, and set err_sticky[uid] on an accepted beat with resp != 0.
REQ-020 SHALL queue drain requests in a DQ_DEPTH FIFO; drain_req_ready = !queue_full; requests are served in acceptance order.
REQ-021 SHALL use drain FSM IDLE/DRAIN: IDLE -> DRAIN loads head of queue into active_uid on the edge the queue is non-empty; DRAIN -> IDLE on last-beat handshake with queue empty; DRAIN -> DRAIN, reloading the next UID, on the same edge when the queue is non-empty.
REQ-022 SHALL drop, not store, an accepted beat for a UID whose seen_last is already set, and pulse proto_err for 1 cycle; r_in.ready stays 1 for it.
REQ-023 SHALL drive r_out combinationally in DRAIN: valid = count[active]!=0; data/resp = head entry; last = seen_last[active] & count[active]==1; in IDLE valid=0, data/resp/last=0.
REQ-024 SHALL, on r_out handshake, advance rptr and decrement count; on last handshake, clear seen_last, err_sticky, pointers of active UID and pulse uid_freed_valid with uid_freed_uid=active, uid_freed_err=err_sticky (including the current beat's resp).
REQ-025 SHALL set flush_ready=0 when flush_uid equals active_uid in DRAIN, when an r_in write targets flush_uid that cycle, or when a drain last-beat handshake occurs that cycle; otherwise 1.
REQ-026 SHALL, on flush handshake, zero the UID's count/pointers/flags, subtract its count from occupancy, and pulse uid_freed_valid with uid_freed_err=1.
REQ-027 SHALL handle simultaneous write and read of the active UID as count unchanged, occupancy unchanged.
REQ-028 SHALL register uid_freed_*, proto_err and full one cycle after the causing edge; occupancy updates on the same edge.
REQ-029 SHALL give one-cycle latency from drain_req handshake (IDLE, non-empty FIFO) to r_out.valid=1.

Reset
REQ-030 SHALL on rst_n=0, asynchronously: all counts, pointers, flags, drain queue, occupancy = 0; FSM = IDLE; uid_freed_valid, proto_err, full, r_out.valid = 0; r_in.ready = 1; reset mid-burst discards all parked beats with no uid_freed pulse.

Verification
REQ-031 SHALL cover: 4 beats UID 3 (last on 4th), drain_req 3 -> 4 r_out beats in order, last on 4th, uid_freed_uid=3, err=0, occupancy 4->0.
REQ-032 SHALL cover: 8 beats UID 5 without last, 9th -> r_in.ready=0 until one beat drained.
REQ-033 SHALL cover: drain_req 1,2 back-to-back, both parked complete -> UID 2 first beat the cycle after UID 1 last handshake, two uid_freed pulses.
REQ-034 SHALL cover: UID 7 beat with resp=2, then flush UID 7 -> uid_freed_err=1, occupancy returns to 0; flush of active UID -> flush_ready=0.
REQ-035 SHALL cover: beat to UID 4 after its last -> dropped, proto_err 1 cycle, occupancy unchanged.
REQ-036 SHALL cover: rst_n low during drain of 3-beat UID -> all outputs reset values, next drain of that UID yields r_out.valid=0.

Source files
------------

// File: rtl/uid_response_park_if.sv
// r_if: read-response beat channel (valid/ready handshake).
//   valid, id, data, resp, last : sender -> receiver
//   ready                       : receiver -> sender
// master/slave are aliases of sender/receiver for tools and teams that prefer those names.
interface r_if #(
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int ID_WIDTH   = 4
) ();
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [RESP_WIDTH-1:0] resp;
    logic                  last;

    modport sender   (output valid, id, data, resp, last, input ready);
    modport receiver (input valid, id, data, resp, last, output ready);
    modport master   (output valid, id, data, resp, last, input ready);
    modport slave    (input valid, id, data, resp, last, output ready);
endinterface

// File: rtl/uid_response_park.sv
// uid_response_park: parks out-of-order response beats in one circular FIFO
// per UID and replays a whole UID burst on request, in request order.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   r_in  (receiver)    : incoming beats, id = UID
//   r_out (sender)      : replayed beats of the active UID
//   drain_req_*         : request to replay a UID (queued, DQ_DEPTH deep)
//   flush_*             : discard everything parked for a UID
//   uid_freed_*         : one-cycle pulse when a UID is released (drained or flushed)
//   proto_err           : one-cycle pulse when a beat after last is dropped
//   occupancy, full     : total parked beats / all storage used
//
// Drain FSM
//   state    | meaning
//   ST_IDLE  | no UID selected, r_out idle
//   ST_DRAIN | active_q selected, r_out presents its head beat
module uid_response_park #(
    parameter int NUM_UIDS   = 16,
    parameter int MAX_BEATS  = 8,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int ID_WIDTH   = $clog2(NUM_UIDS),
    parameter int DQ_DEPTH   = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    r_if.receiver                                       r_in,
    r_if.sender                                         r_out,
    input  logic                                        drain_req_valid,
    output logic                                        drain_req_ready,
    input  logic [ID_WIDTH-1:0]                         drain_req_uid,
    input  logic                                        flush_valid,
    output logic                                        flush_ready,
    input  logic [ID_WIDTH-1:0]                         flush_uid,
    output logic                                        uid_freed_valid,
    output logic [ID_WIDTH-1:0]                         uid_freed_uid,
    output logic                                        uid_freed_err,
    output logic                                        proto_err,
    output logic [$clog2(NUM_UIDS*MAX_BEATS+1)-1:0]     occupancy,
    output logic                                        full
);
    localparam int PTR_W = $clog2(MAX_BEATS);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
    localparam int OCC_W = $clog2(NUM_UIDS * MAX_BEATS + 1);
    localparam int TOTAL = NUM_UIDS * MAX_BEATS;
    localparam int DQ_PW = $clog2(DQ_DEPTH);
    localparam int DQ_CW = $clog2(DQ_DEPTH + 1);

    typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   active_q, active_d;

    logic [DATA_WIDTH-1:0] mem_data [NUM_UIDS][MAX_BEATS];
    logic [RESP_WIDTH-1:0] mem_resp [NUM_UIDS][MAX_BEATS];
    logic [PTR_W-1:0]      wptr_q [NUM_UIDS];
    logic [PTR_W-1:0]      wptr_d [NUM_UIDS];
    logic [PTR_W-1:0]      rptr_q [NUM_UIDS];
    logic [PTR_W-1:0]      rptr_d [NUM_UIDS];
    logic [CNT_W-1:0]      count_q [NUM_UIDS];
    logic [CNT_W-1:0]      count_d [NUM_UIDS];
    logic [NUM_UIDS-1:0]   seen_last_q, seen_last_d;
    logic [NUM_UIDS-1:0]   err_sticky_q, err_sticky_d;

    logic [ID_WIDTH-1:0]   dq_mem_q [DQ_DEPTH];
    logic [DQ_PW-1:0]      dq_wptr_q, dq_rptr_q;
    logic [DQ_CW-1:0]      dq_count_q;

    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  full_q;
    logic                  freed_valid_q, freed_err_q, proto_err_q;
    logic [ID_WIDTH-1:0]   freed_uid_q;

    logic wr_fire, wr_store, wr_drop;
    logic out_valid, out_last, draining;
    logic rd_fire, rd_last;
    logic dq_empty, dq_full, dr_fire, head_valid, load, dq_push, dq_pop;
    logic flush_fire;
    logic [ID_WIDTH-1:0] head_uid;
    logic [CNT_W-1:0]    act_count;
    logic [PTR_W-1:0]    act_rptr;

    // ---------------- input side ----------------
    // A UID that has already seen last keeps ready high so stray beats are
    // swallowed (and flagged) instead of stalling the shared channel.
    assign r_in.ready = seen_last_q[r_in.id] | (count_q[r_in.id] != CNT_W'(MAX_BEATS));
    assign wr_fire    = r_in.valid & r_in.ready;
    assign wr_drop    = wr_fire & seen_last_q[r_in.id];
    assign wr_store   = wr_fire & ~seen_last_q[r_in.id];

    // ---------------- output side ----------------
    assign draining  = (state_q == ST_DRAIN);
    assign act_count = count_q[active_q];
    assign act_rptr  = rptr_q[active_q];
    assign out_valid = draining & (act_count != '0);
    assign out_last  = draining & seen_last_q[active_q] & (act_count == CNT_W'(1));

    assign r_out.valid = out_valid;
    assign r_out.last  = out_last;
    assign r_out.id    = draining ? active_q : '0;
    assign r_out.data  = draining ? mem_data[active_q][act_rptr] : '0;
    assign r_out.resp  = draining ? mem_resp[active_q][act_rptr] : '0;

    assign rd_fire = out_valid & r_out.ready;
    assign rd_last = rd_fire & out_last;

    // ---------------- drain request queue ----------------
    assign dq_empty        = (dq_count_q == '0);
    assign dq_full         = (dq_count_q == DQ_CW'(DQ_DEPTH));
    assign drain_req_ready = ~dq_full;
    assign dr_fire         = drain_req_valid & drain_req_ready;

    // An incoming request bypasses an empty queue so the first beat appears
    // the cycle right after the request handshake.
    assign head_valid = ~dq_empty | dr_fire;
    assign head_uid   = dq_empty ? drain_req_uid : dq_mem_q[dq_rptr_q];
    assign dq_pop     = load & ~dq_empty;
    assign dq_push    = dr_fire & ~(load & dq_empty);

    // ---------------- drain FSM ----------------
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (head_valid) load = 1'b1;
            end
            ST_DRAIN: begin
                if (rd_last) begin
                    if (head_valid) load = 1'b1;
                    else            state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            state_d  = ST_DRAIN;
            active_d = head_uid;
        end
    end

    // ---------------- flush ----------------
    // Blocked whenever the same cycle already touches that UID's bookkeeping,
    // or a release pulse is being generated by the drain.
    assign flush_ready = ~((draining && (flush_uid == active_q)) ||
                           (wr_fire && (r_in.id == flush_uid)) ||
                           rd_last);
    assign flush_fire  = flush_valid & flush_ready;

    // ---------------- per-UID bookkeeping ----------------
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        seen_last_d  = seen_last_q;
        err_sticky_d = err_sticky_q;
        if (wr_store) begin
            wptr_d[r_in.id]  = wptr_q[r_in.id] + PTR_W'(1);
            count_d[r_in.id] = count_d[r_in.id] + CNT_W'(1);
            if (r_in.last)         seen_last_d[r_in.id]  = 1'b1;
            if (r_in.resp != '0)   err_sticky_d[r_in.id] = 1'b1;
        end
        if (rd_fire) begin
            rptr_d[active_q]  = rptr_q[active_q] + PTR_W'(1);
            count_d[active_q] = count_d[active_q] - CNT_W'(1);
        end
        // A write to the active UID in this cycle is a drop (seen_last set),
        // so clearing the whole entry loses nothing.
        if (rd_last) begin
            wptr_d[active_q]       = '0;
            rptr_d[active_q]       = '0;
            count_d[active_q]      = '0;
            seen_last_d[active_q]  = 1'b0;
            err_sticky_d[active_q] = 1'b0;
        end
        if (flush_fire) begin
            wptr_d[flush_uid]       = '0;
            rptr_d[flush_uid]       = '0;
            count_d[flush_uid]      = '0;
            seen_last_d[flush_uid]  = 1'b0;
            err_sticky_d[flush_uid] = 1'b0;
        end
    end

    always_comb begin
        occ_d = occ_q + OCC_W'(wr_store) - OCC_W'(rd_fire);
        if (flush_fire) occ_d = occ_d - OCC_W'(count_q[flush_uid]);
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_UIDS; i++) begin
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
                count_q[i] <= '0;
            end
            seen_last_q  <= '0;
            err_sticky_q <= '0;
            occ_q        <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            seen_last_q  <= seen_last_d;
            err_sticky_q <= err_sticky_d;
            occ_q        <= occ_d;
        end
    end

    // Beat storage carries no reset; validity comes from count/pointers.
    always_ff @(posedge clk) begin
        if (wr_store) begin
            mem_data[r_in.id][wptr_q[r_in.id]] <= r_in.data;
            mem_resp[r_in.id][wptr_q[r_in.id]] <= r_in.resp;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DQ_DEPTH; i++) dq_mem_q[i] <= '0;
            dq_wptr_q  <= '0;
            dq_rptr_q  <= '0;
            dq_count_q <= '0;
        end else begin
            if (dq_push) begin
                dq_mem_q[dq_wptr_q] <= drain_req_uid;
                dq_wptr_q           <= dq_wptr_q + DQ_PW'(1);
            end
            if (dq_pop) dq_rptr_q <= dq_rptr_q + DQ_PW'(1);
            dq_count_q <= dq_count_q + DQ_CW'(dq_push) - DQ_CW'(dq_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freed_valid_q <= 1'b0;
            freed_uid_q   <= '0;
            freed_err_q   <= 1'b0;
            proto_err_q   <= 1'b0;
            full_q        <= 1'b0;
        end else begin
            freed_valid_q <= rd_last | flush_fire;
            if (rd_last) begin
                freed_uid_q <= active_q;
                freed_err_q <= err_sticky_q[active_q] | (r_out.resp != '0);
            end else if (flush_fire) begin
                freed_uid_q <= flush_uid;
                freed_err_q <= 1'b1;
            end
            proto_err_q <= wr_drop;
            full_q      <= (occ_d == OCC_W'(TOTAL));
        end
    end

    assign uid_freed_valid = freed_valid_q;
    assign uid_freed_uid   = freed_uid_q;
    assign uid_freed_err   = freed_err_q;
    assign proto_err       = proto_err_q;
    assign occupancy       = occ_q;
    assign full            = full_q;
endmodule

// File: tb/tb_uid_response_park.sv
module tb_uid_response_park;
    localparam int NU = 16;
    localparam int MB = 8;
    localparam int DW = 64;
    localparam int RW = 2;
    localparam int IW = 4;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          drain_req_valid, drain_req_ready;
    logic [IW-1:0] drain_req_uid;
    logic          flush_valid, flush_ready;
    logic [IW-1:0] flush_uid;
    logic          uid_freed_valid, uid_freed_err, proto_err, full;
    logic [IW-1:0] uid_freed_uid;
    logic [OW-1:0] occupancy;

    always #5 clk = ~clk;

    r_if #(.DATA_WIDTH(DW), .RESP_WIDTH(RW), .ID_WIDTH(IW)) r_in_if ();
    r_if #(.DATA_WIDTH(DW), .RESP_WIDTH(RW), .ID_WIDTH(IW)) r_out_if ();

    uid_response_park #(
        .NUM_UIDS(NU), .MAX_BEATS(MB), .DATA_WIDTH(DW), .RESP_WIDTH(RW),
        .ID_WIDTH(IW), .DQ_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .r_in(r_in_if), .r_out(r_out_if),
        .drain_req_valid(drain_req_valid), .drain_req_ready(drain_req_ready),
        .drain_req_uid(drain_req_uid),
        .flush_valid(flush_valid), .flush_ready(flush_ready), .flush_uid(flush_uid),
        .uid_freed_valid(uid_freed_valid), .uid_freed_uid(uid_freed_uid),
        .uid_freed_err(uid_freed_err),
        .proto_err(proto_err), .occupancy(occupancy), .full(full)
    );

    typedef struct packed {
        logic [IW-1:0] u;
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        logic          l;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] u;
        logic          e;
    } freed_t;

    typedef struct {
        int          u;
        logic [63:0] d;
        logic [1:0]  r;
        logic        l;
        logic        exp_rdy;
        logic        exp_drop;
        int          exp_occ;
    } vec_t;

    beat_t  mdl [NU][$];
    beat_t  exp_q [$];
    freed_t freed_q [$];
    bit     in_drain [NU];
    bit     pend_b2b = 1'b0;
    beat_t  mon_e;
    freed_t wf;
    int     errors = 0;
    int     checks = 0;
    vec_t   vt [10];

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard consumer and release-pulse logger, sampled mid-cycle.
    always @(negedge clk) begin
        if (pend_b2b) begin
            chk("b2b_valid", 128'(r_out_if.valid), 128'(1));
            pend_b2b = 1'b0;
        end
        if (rst_n && r_out_if.valid && r_out_if.ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got id %0h data %0h, expected none", r_out_if.id, r_out_if.data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rout_beat", 128'({r_out_if.id, r_out_if.data, r_out_if.resp, r_out_if.last}), 128'(mon_e));
                if (r_out_if.last && exp_q.size() > 0) pend_b2b = 1'b1;
            end
        end
        if (uid_freed_valid) begin
            freed_q.push_back({uid_freed_uid, uid_freed_err});
            in_drain[uid_freed_uid] = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic record_beat(input int u, input logic [63:0] d, input logic [1:0] r, input logic l);
        if (in_drain[u]) exp_q.push_back({4'(u), d, r, l});
        else             mdl[u].push_back({4'(u), d, r, l});
    endtask

    task automatic write_beat(input int u, input logic [63:0] d, input logic [1:0] r, input logic l,
                              input logic exp_drop);
        r_in_if.valid = 1'b1;
        r_in_if.id    = 4'(u);
        r_in_if.data  = d;
        r_in_if.resp  = r;
        r_in_if.last  = l;
        #1;
        chk("rin_ready", 128'(r_in_if.ready), 128'(1));
        tick();
        chk("proto_err", 128'(proto_err), 128'(exp_drop));
        r_in_if.valid = 1'b0;
        if (!exp_drop) record_beat(u, d, r, l);
    endtask

    task automatic drain(input int u, input logic exp_v);
        chk("dreq_ready", 128'(drain_req_ready), 128'(1));
        drain_req_valid = 1'b1;
        drain_req_uid   = 4'(u);
        in_drain[u]     = 1'b1;
        while (mdl[u].size() > 0) exp_q.push_back(mdl[u].pop_front());
        tick();
        drain_req_valid = 1'b0;
        chk("rout_valid_lat", 128'(r_out_if.valid), 128'(exp_v));
    endtask

    task automatic wait_freed(input int u, input logic e);
        int n;
        n = 0;
        while (freed_q.size() == 0 && n < 40) begin
            tick();
            n++;
        end
        if (freed_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL freed_timeout: got no pulse, expected uid %0d", u);
        end else begin
            wf = freed_q.pop_front();
            chk("freed_uid", 128'(wf.u), 128'(u));
            chk("freed_err", 128'(wf.e), 128'(e));
        end
    endtask

    initial begin
        vt[0] = '{3, 64'hA0, 2'd0, 1'b0, 1'b1, 1'b0, 1};
        vt[1] = '{3, 64'hA1, 2'd0, 1'b0, 1'b1, 1'b0, 2};
        vt[2] = '{3, 64'hA2, 2'd0, 1'b0, 1'b1, 1'b0, 3};
        vt[3] = '{3, 64'hA3, 2'd0, 1'b1, 1'b1, 1'b0, 4};
        vt[4] = '{4, 64'hB0, 2'd0, 1'b1, 1'b1, 1'b0, 5};
        vt[5] = '{4, 64'hB1, 2'd0, 1'b0, 1'b1, 1'b1, 5};
        vt[6] = '{7, 64'hC0, 2'd2, 1'b0, 1'b1, 1'b0, 6};
        vt[7] = '{1, 64'hD0, 2'd0, 1'b0, 1'b1, 1'b0, 7};
        vt[8] = '{1, 64'hD1, 2'd0, 1'b1, 1'b1, 1'b0, 8};
        vt[9] = '{2, 64'hE0, 2'd0, 1'b1, 1'b1, 1'b0, 9};

        r_in_if.valid = 1'b0; r_in_if.id = '0; r_in_if.data = '0; r_in_if.resp = '0; r_in_if.last = 1'b0;
        r_out_if.ready = 1'b1;
        drain_req_valid = 1'b0; drain_req_uid = '0;
        flush_valid = 1'b0; flush_uid = '0;
        for (int i = 0; i < NU; i++) in_drain[i] = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_rout_valid", 128'(r_out_if.valid), 128'(0));
        chk("rst_rin_ready", 128'(r_in_if.ready), 128'(1));
        chk("rst_occ", 128'(occupancy), 128'(0));
        chk("rst_full", 128'(full), 128'(0));
        chk("rst_freed", 128'(uid_freed_valid), 128'(0));
        chk("rst_proto", 128'(proto_err), 128'(0));
        chk("rst_dreq_ready", 128'(drain_req_ready), 128'(1));
        chk("rst_flush_ready", 128'(flush_ready), 128'(1));
        rst_n = 1'b1;
        tick();

        // table-driven parking, including a beat after last
        for (int i = 0; i < 10; i++) begin
            r_in_if.valid = 1'b1;
            r_in_if.id    = 4'(vt[i].u);
            r_in_if.data  = vt[i].d;
            r_in_if.resp  = vt[i].r;
            r_in_if.last  = vt[i].l;
            #1;
            chk("vec_ready", 128'(r_in_if.ready), 128'(vt[i].exp_rdy));
            tick();
            chk("vec_occ", 128'(occupancy), 128'(vt[i].exp_occ));
            chk("vec_proto", 128'(proto_err), 128'(vt[i].exp_drop));
            if (!vt[i].exp_drop) record_beat(vt[i].u, vt[i].d, vt[i].r, vt[i].l);
        end
        r_in_if.valid = 1'b0;
        tick();
        chk("proto_one_cycle", 128'(proto_err), 128'(0));

        // single-UID drains
        drain(3, 1'b1);
        wait_freed(3, 1'b0);
        chk("occ_after_3", 128'(occupancy), 128'(5));
        drain(4, 1'b1);
        wait_freed(4, 1'b0);
        chk("occ_after_4", 128'(occupancy), 128'(4));

        // queued drains with flush of the active and a parked UID
        r_out_if.ready = 1'b0;
        drain(1, 1'b1);
        drain(2, 1'b1);
        flush_valid = 1'b1;
        flush_uid   = 4'd1;
        #1;
        chk("flush_active_blocked", 128'(flush_ready), 128'(0));
        flush_uid = 4'd7;
        #1;
        chk("flush_ready", 128'(flush_ready), 128'(1));
        tick();
        flush_valid = 1'b0;
        mdl[7].delete();
        chk("flush_pulse", 128'(uid_freed_valid), 128'(1));
        chk("flush_err_direct", 128'(uid_freed_err), 128'(1));
        wait_freed(7, 1'b1);
        chk("occ_after_flush", 128'(occupancy), 128'(3));
        r_out_if.ready = 1'b1;
        wait_freed(1, 1'b0);
        wait_freed(2, 1'b0);
        chk("occ_after_12", 128'(occupancy), 128'(0));
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        // per-UID backpressure
        for (int b = 0; b < MB; b++) write_beat(5, 64'h500 + 64'(b), 2'd0, 1'b0, 1'b0);
        r_in_if.valid = 1'b1;
        r_in_if.id    = 4'd5;
        r_in_if.data  = 64'h5FF;
        r_in_if.last  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("rin_full_stall", 128'(r_in_if.ready), 128'(0));
            tick();
        end
        r_in_if.valid = 1'b0;
        chk("occ_full_uid", 128'(occupancy), 128'(8));
        r_in_if.id = 4'd6;
        #1;
        chk("rin_other_uid", 128'(r_in_if.ready), 128'(1));
        r_out_if.ready = 1'b0;
        drain(5, 1'b1);
        r_out_if.ready = 1'b1;
        tick();
        r_out_if.ready = 1'b0;
        chk("occ_one_out", 128'(occupancy), 128'(7));
        r_in_if.id = 4'd5;
        #1;
        chk("rin_ready_again", 128'(r_in_if.ready), 128'(1));
        write_beat(5, 64'h5FF, 2'd0, 1'b1, 1'b0);
        r_out_if.ready = 1'b1;
        wait_freed(5, 1'b0);
        chk("occ_after_5", 128'(occupancy), 128'(0));

        // fill all storage, then flush every UID
        for (int u = 0; u < NU; u++)
            for (int b = 0; b < MB; b++)
                write_beat(u, 64'h1000 + 64'(u * 16 + b), 2'd0, 1'b0, 1'b0);
        r_in_if.id = 4'd0;
        #1;
        chk("full_flag", 128'(full), 128'(1));
        chk("occ_full", 128'(occupancy), 128'(NU * MB));
        chk("rin_ready_full", 128'(r_in_if.ready), 128'(0));
        for (int u = 0; u < NU; u++) begin
            flush_valid = 1'b1;
            flush_uid   = 4'(u);
            #1;
            chk("flush_ready_idle", 128'(flush_ready), 128'(1));
            tick();
            flush_valid = 1'b0;
            mdl[u].delete();
            if (u == 0) begin
                chk("full_cleared", 128'(full), 128'(0));
                chk("occ_after_flush0", 128'(occupancy), 128'(NU * MB - MB));
            end
            wait_freed(u, 1'b1);
        end
        chk("occ_all_flushed", 128'(occupancy), 128'(0));

        // reset in the middle of a drain
        r_out_if.ready = 1'b0;
        write_beat(6, 64'h600, 2'd0, 1'b0, 1'b0);
        write_beat(6, 64'h601, 2'd0, 1'b0, 1'b0);
        write_beat(6, 64'h602, 2'd0, 1'b1, 1'b0);
        drain(6, 1'b1);
        #2;
        rst_n = 1'b0;
        r_in_if.id = 4'd6;
        #1;
        chk("mid_rst_rout_valid", 128'(r_out_if.valid), 128'(0));
        chk("mid_rst_occ", 128'(occupancy), 128'(0));
        chk("mid_rst_full", 128'(full), 128'(0));
        chk("mid_rst_freed", 128'(uid_freed_valid), 128'(0));
        chk("mid_rst_proto", 128'(proto_err), 128'(0));
        chk("mid_rst_rin_ready", 128'(r_in_if.ready), 128'(1));
        chk("mid_rst_dreq_ready", 128'(drain_req_ready), 128'(1));
        exp_q.delete();
        mdl[6].delete();
        for (int i = 0; i < NU; i++) in_drain[i] = 1'b0;
        tick();
        rst_n = 1'b1;
        r_out_if.ready = 1'b1;
        drain(6, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("post_rst_no_beats", 128'(r_out_if.valid), 128'(0));
        end
        chk("post_rst_no_freed", 128'(freed_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
